// File: rtl/onehot_demux_stream_pkg.sv
// Package for the one-hot stream demux: shared limits and the error-counter helper.
package onehot_demux_stream_pkg;

`include "onehot_defs.vh"

  // Saturating increment; holds at all-ones.
  function automatic logic [ONEHOT_ERR_COUNT_W-1:0] sat_inc(input logic [ONEHOT_ERR_COUNT_W-1:0] v);
    if (v == {ONEHOT_ERR_COUNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(ONEHOT_ERR_COUNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot / all-zero classifier for an N-bit select bitmap.
module onehot_check #(
  parameter int N = 2
) (
  input  logic [N-1:0] vec,
  output logic         is_onehot,
  output logic         is_zero
);

  logic seen_s;
  logic multi_s;

  // Scan the bitmap, noting whether any bit and whether a second bit is set.
  always_comb begin
    seen_s  = 1'b0;
    multi_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      multi_s = multi_s | (seen_s & vec[i]);
      seen_s  = seen_s | vec[i];
    end
  end

  assign is_zero   = ~seen_s;
  assign is_onehot = seen_s & ~multi_s;

endmodule

// File: rtl/onehot_defs.vh
// Shared definitions for one-hot bitmap-select blocks.
// Define ONEHOT_DEMUX_ERR_COUNT_EN to add the saturating err_count output to onehot_demux_stream.
`ifndef ONEHOT_DEFS_VH
`define ONEHOT_DEFS_VH

localparam int ONEHOT_MAX_OUTPUTS = 32;
localparam int ONEHOT_ERR_COUNT_W = 16;

`endif

// File: rtl/onehot_demux_stream.sv
// Valid/ready stream demux to N channels by one-hot select, with a 2-entry skid buffer.
// Optional macro ONEHOT_DEMUX_ERR_COUNT_EN adds a saturating illegal-select counter port.
module onehot_demux_stream
  import onehot_demux_stream_pkg::*;
#(
  parameter int N_OUTPUTS = 2,
  parameter int W_DATA    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_DATA-1:0]    in_data,
  input  logic [N_OUTPUTS-1:0] in_sel,
  output logic [N_OUTPUTS-1:0] out_valid,
  input  logic [N_OUTPUTS-1:0] out_ready,
  output logic [W_DATA-1:0]    out_data,
  output logic                 err_sel
`ifdef ONEHOT_DEMUX_ERR_COUNT_EN
  ,
  output logic [ONEHOT_ERR_COUNT_W-1:0] err_count
`endif
);

  logic [W_DATA-1:0]    main_data_r, main_data_s;
  logic [N_OUTPUTS-1:0] main_sel_r, main_sel_s;
  logic                 main_valid_r, main_valid_s;
  logic [W_DATA-1:0]    skid_data_r, skid_data_s;
  logic [N_OUTPUTS-1:0] skid_sel_r, skid_sel_s;
  logic                 skid_valid_r, skid_valid_s;
  logic                 in_ready_r;
  logic                 err_sel_r;

  logic sel_onehot_s;
  logic sel_zero_s;
  logic sel_legal_s;
  logic accept_s;
  logic legal_acc_s;
  logic illegal_acc_s;
  logic pop_s;

  onehot_check #(.N(N_OUTPUTS)) u_sel_check (
    .vec       (in_sel),
    .is_onehot (sel_onehot_s),
    .is_zero   (sel_zero_s)
  );

  assign sel_legal_s   = sel_onehot_s & ~sel_zero_s;
  assign accept_s      = in_valid & in_ready_r;
  assign legal_acc_s   = accept_s & sel_legal_s;
  assign illegal_acc_s = accept_s & ~sel_legal_s;

  assign out_valid = main_valid_r ? main_sel_r : {N_OUTPUTS{1'b0}};
  assign out_data  = main_data_r;
  assign in_ready  = in_ready_r;
  assign err_sel   = err_sel_r;
  // Unselected channels cannot pop because out_valid masks their ready.
  assign pop_s     = |(out_valid & out_ready);

  // Next state of the main/skid pair; skid is never full while accepting.
  always_comb begin
    main_data_s  = main_data_r;
    main_sel_s   = main_sel_r;
    main_valid_s = main_valid_r;
    skid_data_s  = skid_data_r;
    skid_sel_s   = skid_sel_r;
    skid_valid_s = skid_valid_r;
    if (pop_s) begin
      if (skid_valid_r) begin
        main_data_s  = skid_data_r;
        main_sel_s   = skid_sel_r;
        main_valid_s = 1'b1;
        skid_valid_s = 1'b0;
      end else if (legal_acc_s) begin
        main_data_s  = in_data;
        main_sel_s   = in_sel;
        main_valid_s = 1'b1;
      end else begin
        main_valid_s = 1'b0;
      end
    end else begin
      if (legal_acc_s) begin
        if (main_valid_r) begin
          skid_data_s  = in_data;
          skid_sel_s   = in_sel;
          skid_valid_s = 1'b1;
        end else begin
          main_data_s  = in_data;
          main_sel_s   = in_sel;
          main_valid_s = 1'b1;
        end
      end else begin
        main_valid_s = main_valid_r;
      end
    end
  end

  // Buffer registers, registered in_ready and the illegal-select pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_r  <= {W_DATA{1'b0}};
      main_sel_r   <= {N_OUTPUTS{1'b0}};
      main_valid_r <= 1'b0;
      skid_data_r  <= {W_DATA{1'b0}};
      skid_sel_r   <= {N_OUTPUTS{1'b0}};
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
      err_sel_r    <= 1'b0;
    end else begin
      main_data_r  <= main_data_s;
      main_sel_r   <= main_sel_s;
      main_valid_r <= main_valid_s;
      skid_data_r  <= skid_data_s;
      skid_sel_r   <= skid_sel_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= ~skid_valid_s;
      err_sel_r    <= illegal_acc_s;
    end
  end

`ifdef ONEHOT_DEMUX_ERR_COUNT_EN
  logic [ONEHOT_ERR_COUNT_W-1:0] err_count_r;

  // Saturating count of accepted illegal-select beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= {ONEHOT_ERR_COUNT_W{1'b0}};
    end else if (illegal_acc_s) begin
      err_count_r <= sat_inc(err_count_r);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`endif

endmodule

// File: doc/onehot_demux_stream.md
Name: onehot_demux_stream

Overview:
- Single valid/ready input stream, routed to exactly one of N output channels by a one-hot destination bitmap carried with each beat.
- Performs the distribution direction that mirrors the bitmap-select mux, e.g. routing bus responses back to the requesting master.
- Fully registered: a 2-entry skid buffer breaks both the valid/data path and the ready path.
- Beats with an illegal selector (zero or multi-hot) are consumed, dropped and flagged.

Parameters:
- N_OUTPUTS, 2, number of downstream channels; legal range 1..32.
- W_DATA, 32, payload width in bits.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  upstream may transfer; driven from a register.
- in_data  input  W_DATA  upstream payload.
- in_sel  input  N_OUTPUTS  one-hot destination bitmap.
- out_valid  output  N_OUTPUTS  per-channel valid; at most one bit set.
- out_ready  input  N_OUTPUTS  per-channel ready.
- out_data  output  W_DATA  payload, shared by all channels.
- err_sel  output  1  one-cycle pulse, cycle after an illegal-selector beat is accepted.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Values while rst is high, and on the first edge after it:
  - main_valid=0, skid_valid=0, in_ready=1, out_valid=0, out_data=0, err_sel=0.
- Input transfer: in_valid && in_ready.
- Output transfer on channel k: out_valid[k] && out_ready[k].
- Output pop: transfer on the channel selected by main_sel, i.e. (out_valid & out_ready) != 0.
- Storage:
  - Main register holds {main_data, main_sel, main_valid}.
  - Skid register holds {skid_data, skid_sel, skid_valid}.
- Output drive: out_valid = {N{main_valid}} & main_sel; out_data = main_data.
- in_ready is registered: in_ready(next) = !skid_valid(next).
- Latency: a beat accepted at edge t appears on out_valid from cycle t+1. Throughput is 1 beat/cycle while the selected out_ready is held high.
- Legality check: in_sel is legal iff exactly one bit is set.
- Illegal selector:
  - The beat is accepted (if in_ready), never written to main or skid.
  - err_sel is high for exactly the next cycle. Back-to-back illegal beats hold err_sel high continuously.
- Legal accept, per edge, in priority order:
  - (a) Main empty, or main popping this cycle with skid empty: the beat loads main.
  - (b) Main full and not popping: the beat loads skid; in_ready drops next cycle.
- Pop: on a pop, main loads from skid if skid_valid (skid clears). Otherwise main loads the incoming legal beat if present; else main_valid clears.
- Simultaneous accept, pop and skid-full cannot occur, because in_ready=0 whenever skid_valid=1.
- Ordering: beats leave in acceptance order across all channels. A stalled channel blocks all others (head-of-line blocking by design).
- out_ready bits of unselected channels are ignored. out_data is held stable while main_valid && !pop.
- Reset mid-operation: both entries are discarded without any output transfer, and no err_sel is issued for a beat in flight.
- N_OUTPUTS=1: a legal selector is 1'b1; 1'b0 is illegal.

Optional Feature:
- Macro: ONEHOT_DEMUX_ERR_COUNT_EN.
- Defined:
  - Extra output port err_count [15:0]: saturating count of illegal-selector beats.
  - Increments on the same edge that schedules err_sel and holds at 16'hffff.
  - Cleared to 0 by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared include onehot_defs.vh holds:
  - the max N_OUTPUTS localparam;
  - the err_count width localparam (16);
  - the ONEHOT_DEMUX_ERR_COUNT_EN usage note.
- Sub-module onehot_check (N parameter): combinational is_onehot and is_zero flags, reused by other bitmap-select blocks.
- Skid-buffer control stays inline.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, err_sel=0 throughout; no beat appears after rst drops.
- Streaming: N=4; beats 0xA0..0xA7 with sel 0001,0010,0100,1000 repeating; all out_ready=1 -> each beat on the matching channel, exactly 1 cycle after acceptance, one beat per cycle, no gaps.
- Backpressure: out_ready[2]=0 while beats 0x11 (sel 0100) and 0x22 (sel 0001) arrive on consecutive cycles:
  - in_ready falls in the cycle after 0x22 is accepted;
  - 0x11 is held on ch2 with out_data stable;
  - after out_ready[2]=1 for one cycle, 0x11 then 0x22 leave in order, and in_ready returns to 1.
- Illegal selectors: sel=0000 then sel=0110 back-to-back with payloads 0x33 and 0x44 -> both accepted, err_sel high for 2 cycles, out_valid never set; with the macro, err_count=2.
- Reset mid-stream: main and skid both full, rst pulsed 1 cycle -> next cycle out_valid=0, in_ready=1; the held beats are never delivered.
- Saturation (macro defined): 65540 illegal beats -> err_count stops at 16'hffff; err_sel still pulses for each beat.
